// File: rtl/pulse_period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of the resynchronised input in CE ticks,
// and presents each completed measurement on a one-entry valid/ready output register.
module pulse_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             smpl_clk,
  input  logic             rst_n,
  input  logic             CE,
  input  logic             en,
  input  logic             rise,
  input  logic             fall,
  input  logic             meas_ready,
  input  logic             clr_ovr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_sat,
  output logic             ovr,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] high_cap, high_cap_nxt;
  logic             sat, sat_nxt;
  logic             qrise, qfall, done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Simultaneous rise and fall on a tick are treated as noise and dropped.
  assign qrise = CE & rise & ~fall;
  assign qfall = CE & fall & ~rise;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sat_nxt      = sat;
    high_cap_nxt = high_cap;
    done         = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sat_nxt   = 1'b0;
    end else if (qrise) begin
      state_nxt = HIGH;
      cnt_nxt   = CNT_W'(1);
      sat_nxt   = 1'b0;
      done      = (state == LOW);
    end else if (CE && state != IDLE) begin
      cnt_nxt = sat_inc(cnt);
      sat_nxt = sat | (sat_inc(cnt) == CNT_MAX);
      if (qfall && state == HIGH) begin
        state_nxt    = LOW;
        high_cap_nxt = cnt;
      end
    end
  end

  // Measurement stage: FSM state, tick counter, captured high time
  always_ff @(posedge smpl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sat      <= 1'b0;
      high_cap <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sat      <= sat_nxt;
      high_cap <= high_cap_nxt;
    end
  end

  // Output stage: one-entry holding register with drop/overrun tracking
  always_ff @(posedge smpl_clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_sat    <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      if (done && (!meas_valid || meas_ready)) begin
        meas_valid  <= 1'b1;
        meas_period <= cnt;
        meas_high   <= high_cap;
        meas_sat    <= sat;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
      if (done && meas_valid && !meas_ready) begin
        ovr <= 1'b1;
      end else if (clr_ovr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: expected measurements queued at stimulus time,
// compared when the DUT hands a measurement over (valid and ready).
module tb_pulse_period_meter;

  logic smpl_clk = 1'b0;
  always #5 smpl_clk = ~smpl_clk;

  logic        rst_n, CE, en, rise, fall, meas_ready, clr_ovr;
  logic        meas_valid, meas_sat, ovr, busy;
  logic [15:0] meas_period, meas_high;
  logic        valid4, sat4, ovr4, busy4;
  logic [3:0]  period4, high4;

  pulse_period_meter #(.CNT_W(16)) dut (
    .smpl_clk(smpl_clk), .rst_n(rst_n), .CE(CE), .en(en), .rise(rise), .fall(fall),
    .meas_ready(meas_ready), .clr_ovr(clr_ovr), .meas_valid(meas_valid),
    .meas_period(meas_period), .meas_high(meas_high), .meas_sat(meas_sat),
    .ovr(ovr), .busy(busy)
  );

  pulse_period_meter #(.CNT_W(4)) dut4 (
    .smpl_clk(smpl_clk), .rst_n(rst_n), .CE(CE), .en(en), .rise(rise), .fall(fall),
    .meas_ready(meas_ready), .clr_ovr(clr_ovr), .meas_valid(valid4),
    .meas_period(period4), .meas_high(high4), .meas_sat(sat4),
    .ovr(ovr4), .busy(busy4)
  );

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    logic        sat;
  } meas_t;

  meas_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cep    = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input int p, input int h, input logic s);
    meas_t m;
    m.period = 16'(p);
    m.high   = 16'(h);
    m.sat    = s;
    sb.push_back(m);
  endtask

  // One clock with the given inputs; returns 2 time units after the edge.
  task automatic drive(input logic c, input logic r, input logic f);
    CE   = c;
    rise = r;
    fall = f;
    @(posedge smpl_clk);
    #2;
  endtask

  // One CE tick; rise/fall held across the whole CE interval like the upstream stage.
  task automatic tick(input logic r, input logic f);
    for (int k = 0; k < cep; k++) drive(k == 0, r, f);
  endtask

  task automatic pulse_cycle(input int p, input int h);
    tick(1'b1, 1'b0);
    repeat (h - 1) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (p - h - 1) tick(1'b0, 1'b0);
  endtask

  task automatic disarm();
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    en = 1'b1;
  endtask

  // Handshake monitor: a transfer happens on the next edge whenever valid and ready are both high.
  always @(negedge smpl_clk) begin
    if (rst_n && meas_valid && meas_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 32'(meas_period), 32'hFFFF_FFFF);
      end else begin
        meas_t e;
        e = sb.pop_front();
        chk("out_period", 32'(meas_period), 32'(e.period));
        chk("out_high",   32'(meas_high),   32'(e.high));
        chk("out_sat",    32'(meas_sat),    32'(e.sat));
      end
    end
  end

  initial begin
    rst_n = 1'b0; CE = 1'b0; en = 1'b1; rise = 1'b0; fall = 1'b0;
    meas_ready = 1'b1; clr_ovr = 1'b0;
    #12;
    chk("rst_valid",  32'(meas_valid),  0);
    chk("rst_period", 32'(meas_period), 0);
    chk("rst_high",   32'(meas_high),   0);
    chk("rst_sat",    32'(meas_sat),    0);
    chk("rst_ovr",    32'(ovr),         0);
    chk("rst_busy",   32'(busy),        0);
    rst_n = 1'b1;
    @(posedge smpl_clk);
    #2;

    // Ignored events while idle
    drive(1'b1, 1'b1, 1'b1);
    chk("both_idle_busy", 32'(busy), 0);
    drive(1'b1, 1'b0, 1'b1);
    chk("fall_idle_busy", 32'(busy), 0);

    // CE every clock: rises at 10/30/50, falls at 15/35
    push_exp(20, 5, 1'b0);
    push_exp(20, 5, 1'b0);
    for (int t = 0; t < 56; t++) begin
      drive(1'b1, (t == 10 || t == 30 || t == 50), (t == 15 || t == 35));
      chk("t1_valid_timing", 32'(meas_valid), 32'(t == 30 || t == 50));
    end

    // CE every 4th clock, events held for the whole interval
    disarm();
    chk("disarm_busy", 32'(busy), 0);
    cep = 4;
    push_exp(8, 3, 1'b0);
    push_exp(8, 3, 1'b0);
    pulse_cycle(8, 3);
    pulse_cycle(8, 3);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cep = 1;

    // Back-pressure: first result held, later ones dropped
    disarm();
    meas_ready = 1'b0;
    pulse_cycle(6, 2);
    pulse_cycle(7, 3);
    pulse_cycle(9, 4);
    tick(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("bp_valid",  32'(meas_valid),  1);
    chk("bp_period", 32'(meas_period), 6);
    chk("bp_high",   32'(meas_high),   2);
    chk("bp_ovr",    32'(ovr),         1);
    push_exp(6, 2, 1'b0);
    clr_ovr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    chk("clr_ovr", 32'(ovr), 0);
    meas_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    chk("bp_valid_drop", 32'(meas_valid), 0);

    // Saturation on the 4-bit instance; the 16-bit one measures it exactly
    disarm();
    push_exp(20, 3, 1'b0);
    pulse_cycle(20, 3);
    tick(1'b1, 1'b0);
    chk("sat4_valid",  32'(valid4),  1);
    chk("sat4_period", 32'(period4), 15);
    chk("sat4_high",   32'(high4),   3);
    chk("sat4_sat",    32'(sat4),    1);
    drive(1'b0, 1'b0, 1'b0);

    // Missed fall: second rise restarts without producing output
    disarm();
    tick(1'b1, 1'b0);
    repeat (11) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("missed_fall_no_out", 32'(meas_valid), 0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    push_exp(10, 4, 1'b0);
    tick(1'b1, 1'b0);
    chk("missed_fall_out", 32'(meas_valid), 1);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-HIGH with a held measurement
    disarm();
    meas_ready = 1'b0;
    pulse_cycle(5, 2);
    tick(1'b1, 1'b0);
    chk("pre_rst_valid", 32'(meas_valid), 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("pre_rst_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(meas_valid),  0);
    chk("arst_period", 32'(meas_period), 0);
    chk("arst_high",   32'(meas_high),   0);
    chk("arst_sat",    32'(meas_sat),    0);
    chk("arst_busy",   32'(busy),        0);
    sb.delete();
    #3 rst_n = 1'b1;
    meas_ready = 1'b1;
    @(posedge smpl_clk);
    #2;
    tick(1'b1, 1'b0);
    chk("post_rst_arm_only", 32'(meas_valid), 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    push_exp(4, 2, 1'b0);
    tick(1'b1, 1'b0);
    chk("post_rst_out", 32'(meas_valid), 1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
